// File: rtl/sample_feeder.sv
// Sample feeder for the filtr_a notch filter: FIFO-buffers 24-bit samples and hands them out one at a time.
// Define FEEDER_STATS_EN to add the saturating drop_cnt port.
module sample_feeder #(
  parameter int DATA_SIZE   = 25,
  parameter int FIFO_DEPTH  = 8,
  parameter int AW          = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-2:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [DATA_SIZE-2:0] data_out,
  output logic                 sample_trig,
  input  logic                 filter_done,
  output logic                 busy,
  output logic [AW:0]          fifo_level,
  output logic                 ovf,
  output logic                 timeout_err
`ifdef FEEDER_STATS_EN
  ,
  output logic [15:0]          drop_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, TRIG, WAIT_DONE, HOLD} state_t;

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0]  HOLD_LOAD  = 8'(HOLD_CYCLES);
  localparam logic [7:0]  WAIT_LAST  = 8'(TIMEOUT - 1);

  logic [DATA_SIZE-2:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 drop;

  state_t     state;
  state_t     state_next;
  logic [7:0] cnt;
  logic [7:0] cnt_next;
  logic       wait_expired;

  // Space is judged on the registered level only, so a pop never makes room for a same-cycle push.
  assign full        = (fifo_level == FULL_LEVEL);
  assign empty       = (fifo_level == '0);
  assign s_ready     = !full;
  assign push        = s_valid && !full;
  assign drop        = s_valid && full;
  assign pop         = (state == LOAD);
  assign sample_trig = (state == TRIG);
  assign busy        = (state != IDLE);

  // NOTE: sample storage has no reset; the pointers and level alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    wait_expired = 1'b0;
    case (state)
      IDLE: if (!empty) state_next = LOAD;
      LOAD: state_next = TRIG;
      TRIG: begin
        state_next = WAIT_DONE;
        cnt_next   = '0;
      end
      WAIT_DONE: begin
        if (filter_done) begin
          state_next = HOLD;
          cnt_next   = HOLD_LOAD;
        end else if (cnt == WAIT_LAST) begin
          state_next   = IDLE;
          wait_expired = 1'b1;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      HOLD: begin
        if (cnt == 8'd1) state_next = empty ? IDLE : LOAD;
        else             cnt_next   = cnt - 8'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      data_out    <= '0;
      ovf         <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (pop)          data_out    <= mem[rd_ptr];
      if (drop)         ovf         <= 1'b1;
      if (wait_expired) timeout_err <= 1'b1;
    end
  end

`ifdef FEEDER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset)                            drop_cnt <= '0;
    else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule
